fetch_unit: RTL

- Instruction Fetch (IF) stage, directly upstream of the control unit's decode stage.
- Owns the program counter and issues word reads to the instruction RAM (1-cycle synchronous read).
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch redirects from later stages: flushes buffered and in-flight fetches, restarts at the target.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: address/instruction widths, buffer depth, reset PC.
// Imported by fetch_unit and fetch_fifo.
package fetch_unit_pkg;

  localparam int FETCH_PC_WIDTH    = 14;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int FETCH_DEPTH       = 2;
  localparam int FETCH_RESET_PC    = 0;
  localparam int PC_INCREMENT      = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instruction} pairs for the fetch stage.
// Flush wins over push; storage is zeroed on reset so the head reads 0 afterwards.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int WIDTH = FETCH_PC_WIDTH + FETCH_INSTR_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RAM read issue, response buffering and redirect flush.
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH    = FETCH_PC_WIDTH,
  parameter int                  INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int                  DEPTH       = FETCH_DEPTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   mem_rd_en,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   out_Valid,
  input  logic                   in_Ready,
  output logic [INSTR_WIDTH-1:0] out_Instruction,
  output logic [PC_WIDTH-1:0]    out_Pc,
  output logic [PC_WIDTH-1:0]    pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [15:0]            stat_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic                         inflight_q;
  logic                         kill_q;
  logic [PC_WIDTH-1:0]          inflight_pc_q;
  logic [CW-1:0]                fifo_count;
  logic [PC_WIDTH+INSTR_WIDTH-1:0] fifo_head;
  logic                         deq;
  logic                         push;
  logic [OW-1:0]                occupancy;

  // Slots already committed (buffered + in flight) after this cycle's dequeue.
  assign out_Valid = (fifo_count != '0) && !redirect_valid;
  assign deq       = out_Valid && in_Ready;
  assign occupancy = {1'b0, fifo_count} + OW'(inflight_q) - OW'(deq);
  assign mem_rd_en = !reset && !redirect_valid && (occupancy < OW'(DEPTH));
  assign mem_addr  = pc;
  assign push      = inflight_q && !kill_q;

  assign {out_Pc, out_Instruction} = fifo_head;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      inflight_q    <= mem_rd_en;
      inflight_pc_q <= pc;
      kill_q        <= redirect_valid;
      if (redirect_valid) begin
        pc <= redirect_pc & ~(PC_WIDTH'(3));
      end else if (mem_rd_en) begin
        pc <= pc + PC_WIDTH'(PC_INCREMENT);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_WIDTH + INSTR_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (deq),
    .flush     (redirect_valid),
    .push_data ({inflight_pc_q, mem_rdata}),
    .count     (fifo_count),
    .head      (fifo_head)
  );

`ifdef FETCH_STATS_EN
  // A redirect counts as a flush only when it throws away buffered or in-flight work.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (deq) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (redirect_valid && ((fifo_count != '0) || inflight_q)) begin
        stat_flushed <= stat_flushed + 16'd1;
      end
    end
  end
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule
